iq_gen_deadlock_reporter: RTL and testbench

IQ_GEN_DEADLOCK_REPORTER -- requirements
Module: iq_gen_deadlock_reporter

---
 rtl/iq_gen_deadlock_reporter.sv | 129 ++++++++++++
 tb/tb_iq_gen_deadlock_reporter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/iq_gen_deadlock_reporter.sv
// Qualifies the iq_gen deadlock monitor's block flag, latches the first qualified
// deadlock with its channel info, and reports it once over a valid/ready port.
module iq_gen_deadlock_reporter #(
  parameter int HOLD_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             block_in,
  input  logic [15:0]      info_in,
  input  logic             clr,
  input  logic             rpt_ready,
  output logic             deadlock,
  output logic [15:0]      deadlock_info,
  output logic [CNT_W-1:0] event_count,
  output logic             rpt_valid,
  output logic [31:0]      rpt_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_W = 16'(HOLD_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + CNT_W'(1);
  endfunction

  function automatic logic [15:0] zext16(input logic [CNT_W-1:0] v);
    zext16           = '0;
    zext16[CNT_W-1:0] = v;
  endfunction

  state_t           r_state;
  logic [15:0]      r_run_cnt;
  logic             r_deadlock;
  logic [15:0]      r_info;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rpt_valid;
  logic [31:0]      r_rpt_data;

  state_t           w_state_nxt;
  logic [15:0]      w_run_nxt;
  logic [15:0]      w_run_inc;
  logic             w_dl_nxt;
  logic [15:0]      w_info_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // run_cnt is zero whenever IDLE, so IDLE and ARMED share the same counting rule
  assign w_run_inc = r_run_cnt + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_cnt;
    w_dl_nxt    = r_deadlock;
    w_info_nxt  = r_info;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = IDLE;
      w_run_nxt   = '0;
      w_dl_nxt    = 1'b0;
      w_info_nxt  = '0;
    end else begin
      case (r_state)
        IDLE, ARMED: begin
          if (block_in) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == HOLD_W) begin
              w_state_nxt = REPORT;
              w_dl_nxt    = 1'b1;
              w_info_nxt  = info_in;
              w_cnt_nxt   = sat_inc(r_cnt);
            end else begin
              w_state_nxt = ARMED;
            end
          end else begin
            w_state_nxt = IDLE;
            w_run_nxt   = '0;
          end
        end
        REPORT: begin
          if (rpt_ready) w_state_nxt = DONE;
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_run_nxt   = '0;
          w_dl_nxt    = 1'b0;
          w_info_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state     <= IDLE;
      r_run_cnt   <= '0;
      r_deadlock  <= 1'b0;
      r_info      <= '0;
      r_cnt       <= '0;
      r_rpt_valid <= 1'b0;
      r_rpt_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_cnt   <= w_run_nxt;
      r_deadlock  <= w_dl_nxt;
      r_info      <= w_info_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rpt_valid <= (w_state_nxt == REPORT);
      r_rpt_data  <= {zext16(w_cnt_nxt), w_info_nxt};
    end
  end

  assign deadlock      = r_deadlock;
  assign deadlock_info = r_info;
  assign event_count   = r_cnt;
  assign rpt_valid     = r_rpt_valid;
  assign rpt_data      = r_rpt_data;

endmodule

// File: tb/tb_iq_gen_deadlock_reporter.sv
// Randomized and directed bench for iq_gen_deadlock_reporter: three instances
// (hold 4 / 16-bit count, hold 4 / 2-bit count, hold 1) against a behavioural model.
module tb_iq_gen_deadlock_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        blk = 1'b0;
  logic [15:0] inf = '0;
  logic        cl = 1'b0;
  logic        rdy = 1'b0;

  logic        dl_a, vld_a, dl_b, vld_b, dl_c, vld_c;
  logic [15:0] info_a, info_b, info_c, cnt_a, cnt_c;
  logic [1:0]  cnt_b;
  logic [31:0] data_a, data_b, data_c;

  always #5 clk = ~clk;

  iq_gen_deadlock_reporter #(.HOLD_CYCLES(4), .CNT_W(16)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .block_in(blk), .info_in(inf), .clr(cl),
    .rpt_ready(rdy), .deadlock(dl_a), .deadlock_info(info_a), .event_count(cnt_a),
    .rpt_valid(vld_a), .rpt_data(data_a));

  iq_gen_deadlock_reporter #(.HOLD_CYCLES(4), .CNT_W(2)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .block_in(blk), .info_in(inf), .clr(cl),
    .rpt_ready(rdy), .deadlock(dl_b), .deadlock_info(info_b), .event_count(cnt_b),
    .rpt_valid(vld_b), .rpt_data(data_b));

  iq_gen_deadlock_reporter #(.HOLD_CYCLES(1), .CNT_W(16)) u_c (
    .ap_clk(clk), .ap_rst_n(rst_n), .block_in(blk), .info_in(inf), .clr(cl),
    .rpt_ready(rdy), .deadlock(dl_c), .deadlock_info(info_c), .event_count(cnt_c),
    .rpt_valid(vld_c), .rpt_data(data_c));

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model, one slot per instance
  int          m_streak [3];
  bit          m_latched[3];
  bit          m_pending[3];
  logic [15:0] m_info   [3];
  int          m_events [3];
  int          m_xfer   [3];
  int          o_xfer   [3];

  function automatic int hold_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int maxc_of(input int k);
    return (k == 1) ? 3 : 65535;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int k);
    if (!rst_n) begin
      m_streak[k] = 0; m_latched[k] = 0; m_pending[k] = 0;
      m_info[k] = '0; m_events[k] = 0;
    end else if (cl) begin
      m_streak[k] = 0; m_latched[k] = 0; m_pending[k] = 0; m_info[k] = '0;
    end else if (!m_latched[k]) begin
      if (blk) begin
        m_streak[k]++;
        if (m_streak[k] == hold_of(k)) begin
          m_latched[k] = 1; m_pending[k] = 1; m_info[k] = inf; m_events[k]++;
        end
      end else begin
        m_streak[k] = 0;
      end
    end else if (m_pending[k] && rdy) begin
      m_pending[k] = 0;
      m_xfer[k]++;
    end
  endtask

  task automatic chk_inst(input string nm, input int k, input logic dl, input logic [15:0] ifo,
                          input logic [15:0] cnt, input logic vld, input logic [31:0] dat);
    int c;
    c = (m_events[k] > maxc_of(k)) ? maxc_of(k) : m_events[k];
    chk({nm, "_deadlock"}, {31'b0, dl}, {31'b0, m_latched[k]});
    chk({nm, "_info"}, {16'b0, ifo}, {16'b0, m_info[k]});
    chk({nm, "_count"}, {16'b0, cnt}, c);
    chk({nm, "_valid"}, {31'b0, vld}, {31'b0, m_pending[k]});
    chk({nm, "_data"}, dat, {c[15:0], m_info[k]});
  endtask

  task automatic step(input bit rn, input bit b, input logic [15:0] i, input bit c, input bit r);
    @(negedge clk);
    rst_n = rn; blk = b; inf = i; cl = c; rdy = r;
    if (rn && !c && r) begin
      if (vld_a) o_xfer[0]++;
      if (vld_b) o_xfer[1]++;
      if (vld_c) o_xfer[2]++;
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    chk_inst("a", 0, dl_a, info_a, cnt_a, vld_a, data_a);
    chk_inst("b", 1, dl_b, info_b, {14'b0, cnt_b}, vld_b, data_b);
    chk_inst("c", 2, dl_c, info_c, cnt_c, vld_c, data_c);
  endtask

  task automatic qualify(input logic [15:0] i, input bit r);
    for (int n = 0; n < 3; n++) step(1, 1, 16'h0000, 0, r);
    step(1, 1, i, 0, r);
  endtask

  initial begin
    int vcycles;
    logic [1:0] exp_b [5];
    exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd3; exp_b[4] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      m_streak[k] = 0; m_latched[k] = 0; m_pending[k] = 0;
      m_info[k] = '0; m_events[k] = 0; m_xfer[k] = 0; o_xfer[k] = 0;
    end

    step(0, 0, 16'h0, 0, 0);
    step(0, 1, 16'hABCD, 1, 1);
    chk("reset_valid", {31'b0, vld_a}, 32'd0);
    chk("reset_data", data_a, 32'd0);

    // Three-cycle bursts never qualify on the hold-4 instance
    for (int rep = 0; rep < 2; rep++) begin
      for (int n = 0; n < 3; n++) step(1, 1, 16'hFFFE, 0, 1);
      step(1, 0, 16'hFFFE, 0, 1);
      chk("short_burst_dl", {31'b0, dl_a}, 32'd0);
      chk("short_burst_vld", {31'b0, vld_a}, 32'd0);
    end

    // Immediate acceptance: one valid cycle then DONE
    step(1, 0, 16'h0, 1, 0);
    qualify(16'hFFFE, 1);
    chk("qual_valid", {31'b0, vld_a}, 32'd1);
    chk("qual_data", data_a, 32'h0001_FFFE);
    step(1, 1, 16'h5555, 0, 1);
    chk("done_valid", {31'b0, vld_a}, 32'd0);
    chk("done_dl", {31'b0, dl_a}, 32'd1);
    chk("done_info", {16'b0, info_a}, 32'h0000_FFFE);

    // Backpressure: 10 stalled cycles then accept, 11 valid cycles total
    step(1, 0, 16'h0, 1, 0);
    qualify(16'h1234, 0);
    vcycles = 0;
    for (int n = 0; n < 11; n++) begin
      if (vld_a) vcycles++;
      chk("stall_data", data_a, 32'h0002_1234);
      step(1, 0, 16'h0, 0, (n == 10));
    end
    chk("stall_vcycles", vcycles, 32'd11);
    chk("stall_after_valid", {31'b0, vld_a}, 32'd0);

    // clr wins over rpt_ready; count survives
    step(0, 0, 16'h0, 0, 0);
    qualify(16'h00F0, 0);
    step(1, 0, 16'h0, 1, 1);
    chk("clr_dl", {31'b0, dl_a}, 32'd0);
    chk("clr_cnt", {16'b0, cnt_a}, 32'd1);
    qualify(16'h0F00, 0);
    chk("clr_requal_cnt", {16'b0, data_a[31:16]}, 32'h0002);

    // 2-bit counter saturation
    step(0, 0, 16'h0, 0, 0);
    for (int e = 0; e < 5; e++) begin
      qualify(16'h0101, 0);
      chk("sat_cnt_b", {30'b0, cnt_b}, {30'b0, exp_b[e]});
      step(1, 0, 16'h0, 1, 0);
    end

    // Reset while reporting drops the report
    step(1, 0, 16'h0, 1, 0);
    qualify(16'h7777, 0);
    step(0, 1, 16'h0, 0, 1);
    chk("rst_rep_valid", {31'b0, vld_a}, 32'd0);
    chk("rst_rep_dl", {31'b0, dl_a}, 32'd0);
    chk("rst_rep_cnt", {16'b0, cnt_a}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 8), 16'($urandom),
           ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end

    chk("xfer_a", o_xfer[0], m_xfer[0]);
    chk("xfer_b", o_xfer[1], m_xfer[1]);
    chk("xfer_c", o_xfer[2], m_xfer[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
